seg_counter_n: RTL and testbench
================================

# seg_counter_n

Free-running N-digit counter with a multiplexed 7-segment display driver. It is the parametrised successor to the fixed 4-digit counter used on the board top level, and it drives the digit-select and segment pins directly; pin-polarity inversion stays in the top level. New over the previous generation:
- configurable digit count
- up/down counting and pause
- runtime-programmable tick and scan periods
- clean mode switching between hexadecimal and decimal
- optional leading-zero blanking

## Interface
- `DIGITS`, 4: number of display digits, 1..8.
- `CYC_W`, 32: width of the `cycle` period input.
- `SCAN_W`, 16: width of the `segtiming` scan-period input.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cycle`  in  CYC_W  clocks per count step; 0 and 1 both mean one step per clock.
- `segtiming`  in  SCAN_W  clocks per digit scan slot; 0 is treated as 1.
- `hex`  in  1  level input: 1 = hexadecimal (digits 0..F), 0 = decimal BCD (digits 0..9).
- `up`  in  1  1 = count up, 0 = count down.
- `pause`  in  1  1 = freeze the count value and the tick timer; the scan keeps running.
- `sel`  out  DIGITS  one-hot digit enable, active-high; bit 0 is the least-significant digit.
- `seg`  out  8  active-high segments `{dp,g,f,e,d,c,b,a}`; `dp` is always 0.
- `debug`  out  1  toggles on every count step.

## Operation
- **Tick timer:** counts 0..`cycle`-1 while `pause`=0. On the terminal value it returns to 0 and raises an internal one-clock `step` pulse.
- **Count register:** `DIGITS` 4-bit digits.
  - On `step`, the register increments (`up`=1) or decrements (`up`=0) using a per-digit carry/borrow chain.
  - Digit max is 9 when `hex`=0 and F when `hex`=1.
- **Wrap-around:**
  - Up from all-max (e.g. 9999 or FFFF) gives all-zero.
  - Down from all-zero gives all-max.
- **Mode change:** `hex` is registered once (`hex_q`). A clock where `hex` differs from `hex_q` is a mode change:
  - count register ← 0, tick timer ← 0, `step` suppressed.
  - This takes priority over a simultaneous `step`.
- **Direction change:** takes effect on the next `step`; no clearing.
- **Scan timer:** counts 0..`segtiming`-1. On the terminal value it returns to 0 and the digit index advances modulo `DIGITS` (index `DIGITS`-1 wraps to 0).
- **Outputs:**
  - `sel` ← one-hot of the digit index (registered).
  - `seg` ← 7-segment encoding of the digit at that index, including hex glyphs A b C d E F (registered).
- **Runtime period changes:** a change to `cycle` or `segtiming` is not latched. If a timer's current value is already ≥ the new terminal value, that timer returns to 0 on the next clock.
- **Reset:** all digits 0, both timers 0, digit index 0, `hex_q` ← `hex`, `debug` = 0, `sel` = 1 (digit 0), `seg` = 8'h3F (glyph "0").

## Timing
- Count step: the count register updates on the clock edge after the tick timer reaches `cycle`-1. Steps are `cycle` clocks apart (`cycle` ≥ 1).
- Display latency: `sel`/`seg` reflect the index and count as they were one clock earlier (one register stage).
  - A count change on the active digit appears on `seg` one clock later.
  - A count change on another digit appears when that digit is next scanned.
- Each digit is held for exactly `segtiming` clocks; a full frame is `DIGITS`·`segtiming` clocks.
- `debug` toggles on the same edge the count register updates.
- Reset asserted mid-operation takes effect on the next edge regardless of `pause` and `hex`.
- `pause` asserted stops the tick timer in the same clock; deasserting it resumes from the held timer value.

## Configuration
- `SEG_LZ_BLANK_EN` defined:
  - Leading-zero blanking: a digit drives `seg` = 0 when it and every more-significant digit are 0.
  - Digit 0 is never blanked, so value 0 displays a single "0".
  - `sel` is unaffected.
- `SEG_LZ_BLANK_EN` undefined: every digit always shows its glyph (e.g. "0042").

## Test plan
Bench uses `DIGITS`=4, `cycle`=4, `segtiming`=2 unless stated otherwise.
- **Reset/scan:** pulse `rst` → `sel`=0001 and `seg`=3F. `sel` then steps 0001→0010→0100→1000→0001 every 2 clocks.
- **Decimal count and wrap:**
  - `hex`=0, `up`=1, 40 clocks → count 0010.
  - Starting from count 9999, one step → 0000 and `debug` toggles.
- **Hex count down:**
  - `hex`=1, `up`=0 from reset, one step → FFFF. Digit 0 shows `seg`=71 ("F").
  - Next step → FFFE; digit 0 shows `seg`=79 ("E").
- **Mode change:** count 0123, toggle `hex` in the same clock as a `step` → count 0000, no increment, tick timer restarts at 0.
- **Pause:** `pause`=1 for 20 clocks → count unchanged, scan continues. Release → next step after the remaining tick clocks.
- **Blanking (`SEG_LZ_BLANK_EN`):** count 0042 → digits 3 and 2 drive `seg`=00; digit 1 drives 66 ("4"); digit 0 drives 5B ("2"). Count 0000 → only digit 0 drives 3F.

Source files
------------

// File: rtl/seg_counter_n.sv
// seg_counter_n: N-digit hex/BCD up/down counter driving a multiplexed 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_counter_n #(
  parameter int DIGITS = 4,
  parameter int CYC_W  = 32,
  parameter int SCAN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CYC_W-1:0]  cycle,
  input  logic [SCAN_W-1:0] segtiming,
  input  logic              hex,
  input  logic              up,
  input  logic              pause,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic              debug
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CYC_W-1:0]       tick_cnt;
  logic [CYC_W-1:0]       tick_term;
  logic                   tick_done;
  logic [SCAN_W-1:0]      scan_cnt;
  logic [SCAN_W-1:0]      scan_term;
  logic                   scan_done;
  logic [IDX_W-1:0]       idx;
  logic                   hex_q;
  logic                   mode_chg;
  logic                   step;
  logic [3:0]             dmax;
  logic [DIGITS-1:0][3:0] cnt;
  logic [DIGITS-1:0][3:0] cnt_nx;
  logic [DIGITS-1:0]      lz;
  logic [3:0]             cur;
  logic                   cur_blank;

  // 7-segment glyph {g,f,e,d,c,b,a} for one nibble, hex letters A b C d E F
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Periods of 0 behave as 1; a shrunken period resets an over-range timer
  assign tick_term = (cycle == '0) ? '0 : cycle - CYC_W'(1);
  assign tick_done = (tick_cnt >= tick_term);
  assign scan_term = (segtiming == '0) ? '0 : segtiming - SCAN_W'(1);
  assign scan_done = (scan_cnt >= scan_term);

  assign mode_chg = hex ^ hex_q;
  assign step     = !pause && !mode_chg && tick_done;
  assign dmax     = hex_q ? 4'hF : 4'h9;

  // Remember the display mode so a toggle can be detected
  always_ff @(posedge clk) begin
    hex_q <= hex;
  end

  // Tick timer: frozen by pause, cleared by reset or a mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (mode_chg) begin
      tick_cnt <= '0;
    end else if (!pause) begin
      tick_cnt <= tick_done ? '0 : tick_cnt + CYC_W'(1);
    end
  end

  // Ripple carry/borrow across digits to form the next count value
  always_comb begin
    logic c;
    cnt_nx = cnt;
    c      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (cnt[i] >= dmax) begin
            cnt_nx[i] = 4'h0;
            c         = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + 4'd1;
            c         = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'h0) begin
            cnt_nx[i] = dmax;
            c         = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] - 4'd1;
            c         = 1'b0;
          end
        end
      end
    end
  end

  // Count register: a mode change wins over a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (mode_chg) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt_nx;
    end
  end

  // Debug strobe flips with every count step
  always_ff @(posedge clk) begin
    if (rst) begin
      debug <= 1'b0;
    end else if (step) begin
      debug <= ~debug;
    end
  end

  // Scan timer and digit index; the scan ignores pause
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_done) begin
      scan_cnt <= '0;
      if (idx == IDX_W'(DIGITS - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // Blank a digit when it and everything above it are zero (never digit 0)
  always_comb begin
    logic z;
    lz = '0;
    z  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z     = z && (cnt[i] == 4'h0);
      lz[i] = z && (i != 0);
    end
  end
`else
  assign lz = '0;
`endif

  // Select the digit currently being scanned
  always_comb begin
    cur       = 4'h0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur       = cnt[i];
        cur_blank = lz[i];
      end
    end
  end

  // Registered display outputs, one clock behind index and count
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= DIGITS'(1);
      seg <= 8'h3F;
    end else begin
      sel <= DIGITS'(1) << idx;
      seg <= cur_blank ? 8'h00 : {1'b0, glyph(cur)};
    end
  end

endmodule

// File: tb/tb_seg_counter_n.sv
// tb_seg_counter_n: vector table plus hand sequences for seg_counter_n.
// Expected display frames are queued when stimulus is applied.
module tb_seg_counter_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cycle;
  logic [15:0] segtiming;
  logic        hex;
  logic        up;
  logic        pause;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        debug;

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] sbq[$];

  typedef struct {
    bit          rs;
    bit          hx;
    bit          u;
    logic [31:0] cy;
    int          n;
    logic [15:0] ex;
  } vec_t;

  vec_t vt[11];

  always #5 clk = ~clk;

  seg_counter_n #(
    .DIGITS(4),
    .CYC_W (32),
    .SCAN_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cycle    (cycle),
    .segtiming(segtiming),
    .hex      (hex),
    .up       (up),
    .pause    (pause),
    .sel      (sel),
    .seg      (seg),
    .debug    (debug)
  );

  function automatic logic [7:0] ref_glyph(input logic [3:0] d);
    logic [7:0] t[16];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    return t[d];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Queue the four expected seg bytes for a count value
  task automatic push_exp(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      logic [3:0] d;
      d = v[i*4 +: 4];
      e = ref_glyph(d);
`ifdef SEG_LZ_BLANK_EN
      if (i != 0 && (v >> (i * 4)) == 16'h0) e = 8'h00;
`endif
      sbq.push_back(e);
    end
  endtask

  // Freeze the count, capture one full frame, compare against the queue
  task automatic read_disp(input string name);
    logic [7:0] got[4];
    logic [7:0] e;
    pause = 1'b1;
    for (int j = 0; j < 4; j++) got[j] = 8'hFF;
    tick(2);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      case (sel)
        4'b0001: got[0] = seg;
        4'b0010: got[1] = seg;
        4'b0100: got[2] = seg;
        4'b1000: got[3] = seg;
        default: got[0] = 8'hFE;
      endcase
    end
    for (int j = 0; j < 4; j++) begin
      if (sbq.size() == 0) begin
        e = 8'hFD;
      end else begin
        e = sbq.pop_front();
      end
      check($sformatf("%s.d%0d", name, j), 32'(got[j]), 32'(e));
    end
  endtask

  initial begin
    int ch;
    logic [3:0] prev;

    vt[0]  = '{1'b1, 1'b0, 1'b1, 32'd4, 40,   16'h0010};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 32'd4, 8,    16'h0012};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'd4, 4,    16'h9999};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 32'd4, 4,    16'h0000};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'd4, 4,    16'hFFFF};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 32'd4, 4,    16'hFFFE};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'd4, 12,   16'h0001};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 32'd1, 42,   16'h0042};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 32'd1, 0,    16'h0000};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'd1, 3567, 16'h0DEF};
    vt[10] = '{1'b1, 1'b0, 1'b1, 32'd1, 5678, 16'h5678};

    rst       = 1'b0;
    hex       = 1'b0;
    up        = 1'b1;
    pause     = 1'b1;
    cycle     = 32'd4;
    segtiming = 16'd2;

    // Reset state and scan order
    do_reset();
    check("rst_sel", 32'(sel), 32'h1);
    check("rst_seg", 32'(seg), 32'h3F);
    check("rst_debug", 32'(debug), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("scan_sel%0d", k), 32'(sel),
            32'(1 << (((k - 1) / 2) % 4)));
    end

    // First step lands on the 4th edge with cycle=4
    pause = 1'b0;
    tick(3);
    check("step_early", 32'(debug), 32'h0);
    tick(1);
    check("step_edge", 32'(debug), 32'h1);
    push_exp(16'h0001);
    read_disp("first_step");

    // Mode change coinciding with a step clears and restarts the tick
    hex = 1'b0;
    up  = 1'b1;
    pause = 1'b1;
    do_reset();
    pause = 1'b0;
    push_exp(16'h0123);
    tick(492);
    read_disp("pre_mode");
    check("pre_mode_dbg", 32'(debug), 32'h1);
    pause = 1'b0;
    tick(3);
    hex = 1'b1;
    tick(1);
    check("mode_nostep", 32'(debug), 32'h1);
    tick(3);
    check("mode_restart", 32'(debug), 32'h1);
    tick(1);
    check("mode_step", 32'(debug), 32'h0);
    push_exp(16'h0001);
    read_disp("post_mode");

    // Pause holds count and tick, scan keeps running
    hex = 1'b0;
    pause = 1'b1;
    do_reset();
    pause = 1'b0;
    tick(6);
    check("pause_pre", 32'(debug), 32'h1);
    pause = 1'b1;
    prev = sel;
    ch = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (sel != prev) ch++;
      prev = sel;
    end
    check("pause_hold", 32'(debug), 32'h1);
    check("pause_scan", 32'(ch), 32'd10);
    pause = 1'b0;
    tick(1);
    check("resume_wait", 32'(debug), 32'h1);
    tick(1);
    check("resume_step", 32'(debug), 32'h0);
    push_exp(16'h0002);
    read_disp("pause_val");

    // Shrinking the scan period takes effect immediately
    segtiming = 16'd1;
    tick(2);
    prev = sel;
    ch = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (sel != prev) ch++;
      prev = sel;
    end
    check("scan_fast", 32'(ch), 32'd4);
    segtiming = 16'd2;
    tick(2);

    // Table-driven count vectors
    for (int v = 0; v < 11; v++) begin
      hex   = vt[v].hx;
      up    = vt[v].u;
      cycle = vt[v].cy;
      if (vt[v].rs) begin
        pause = 1'b1;
        do_reset();
      end
      pause = 1'b0;
      push_exp(vt[v].ex);
      tick(vt[v].n);
      read_disp($sformatf("vec%0d", v));
    end

    // Wrap from 9999 toggles debug on the wrap step
    hex   = 1'b0;
    up    = 1'b0;
    cycle = 32'd4;
    pause = 1'b1;
    do_reset();
    pause = 1'b0;
    tick(4);
    check("wrap_dn_dbg", 32'(debug), 32'h1);
    up = 1'b1;
    tick(4);
    check("wrap_up_dbg", 32'(debug), 32'h0);
    push_exp(16'h0000);
    read_disp("wrap_up");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
